// File: rtl/dir_vec_pkg.sv
// dir_vec_pkg: shared state encoding, sweep constants and the expected-value
// helper for the bit-direction stimulus sequencer.
package dir_vec_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned NUM_VECTORS = 256;
  localparam logic [7:0]  ERR_MAX     = 8'd255;
  localparam logic [7:0]  LAST_IDX    = 8'(NUM_VECTORS - 1);

  // Expected out13: bits 3 and 0 exchanged, middle bits unchanged.
  function automatic logic [3:0] swap_msb_lsb(input logic [3:0] a);
    return {a[0], a[2], a[1], a[3]};
  endfunction

endpackage

// File: rtl/dir_vec_check.sv
// dir_vec_check: combinational compare of the datapath outputs against the
// direction-correct values expected for stimulus a.
module dir_vec_check
  import dir_vec_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] obs_out1,
  input  logic [3:0] obs_out2,
  input  logic [7:0] obs_out3,
  input  logic [3:0] obs_out9,
  input  logic [3:0] obs_out13,
  output logic       mismatch
);

  // Any output differing from its expected value flags the vector.
  always_comb begin
    mismatch = (obs_out1  != a)
             | (obs_out2  != a)
             | (obs_out3  != {a, a})
             | (obs_out9  != a)
             | (obs_out13 != swap_msb_lsb(a));
  end

endmodule

// File: rtl/dir_vec_seq.sv
// dir_vec_seq: sweeps all 256 {in2,in1} vectors into the bit-direction
// datapath, waits LATENCY cycles per vector and checks the outputs.
// Optional: DIR_VEC_SEQ_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module dir_vec_seq
  import dir_vec_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] in1,
  output logic [3:0] in2,
  input  logic [3:0] obs_out1,
  input  logic [3:0] obs_out2,
  input  logic [7:0] obs_out3,
  input  logic [3:0] obs_out9,
  input  logic [3:0] obs_out13,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic       fail_valid,
  output logic [7:0] fail_idx
);

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] in1_q, in1_d;
  logic [3:0] in2_q, in2_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [7:0] fail_idx_q, fail_idx_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  dir_vec_check u_check (
    .a         (in1_q),
    .obs_out1  (obs_out1),
    .obs_out2  (obs_out2),
    .obs_out3  (obs_out3),
    .obs_out9  (obs_out9),
    .obs_out13 (obs_out13),
    .mismatch  (mismatch)
  );

  // State, stimulus and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      pass_q       <= pass_d;
    end
  end

  // Sweep sequencing: next state and register updates.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    pass_d       = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = DRIVE;
          idx_d        = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          pass_d       = 1'b0;
        end
      end
      DRIVE: begin
        in1_d   = idx_q[3:0];
        in2_d   = idx_q[7:4];
        cnt_d   = WAIT_LOAD;
        state_d = (LATENCY > 0) ? WAIT : CHECK;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = idx_q;
          end
        end
`ifdef DIR_VEC_SEQ_STOP_ON_FAIL_EN
        if (mismatch || idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DRIVE;
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DRIVE;
        end
`endif
      end
      DONE: begin
        pass_d  = (err_cnt_q == 8'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decode and output mapping.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    in1        = in1_q;
    in2        = in2_q;
    pass       = pass_q;
    err_cnt    = err_cnt_q;
    fail_valid = fail_valid_q;
    fail_idx   = fail_idx_q;
  end

endmodule

// File: doc/dir_vec_seq.md
# dir_vec_seq

Self-checking stimulus sequencer for the bit-direction datapath (`dir_test`-style block: ascending/descending ranges, part-selects, concatenation). It sweeps all 256 `{in2,in1}` combinations into the datapath and waits a configurable latency per vector. It then checks the observed outputs against direction-correct expected values and reports pass/fail with error count and first failing index. It sits beside the datapath in the systest harness as its only driver.

## Interface
- `LATENCY`, 1, cycles between vector drive and observation; legal 0..15
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `in1`  out  4  stimulus to datapath `in1` (registered)
- `in2`  out  4  stimulus to datapath `in2` (registered)
- `obs_out1`  in  4  datapath `out1` ([3:0])
- `obs_out2`  in  4  datapath `out2` ([0:3], bit 0 = MSB)
- `obs_out3`  in  8  datapath `out3`
- `obs_out9`  in  4  datapath `out9`
- `obs_out13`  in  4  datapath `out13`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  last sweep had zero mismatches; held until next start
- `err_cnt`  out  8  mismatching vectors, saturating at 255
- `fail_valid`  out  1  `fail_idx` holds a captured index
- `fail_idx`  out  8  `{in2,in1}` of first mismatching vector

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE: `start`=1 → DRIVE. Index `idx` cleared. `err_cnt`, `fail_valid`, `fail_idx` and `pass` cleared.
- DRIVE (1 cycle): `in1`←`idx[3:0]`, `in2`←`idx[7:4]`. Next state is WAIT if `LATENCY`>0, else CHECK. Wait counter loaded with `LATENCY`-1.
- WAIT: decrement counter; at 0 → CHECK.
- CHECK (1 cycle): with a=`in1`, compare all of the following:
  - `obs_out1`==a
  - `obs_out2`==a (numeric value, range direction irrelevant)
  - `obs_out3`=={a,a}
  - `obs_out9`==a
  - `obs_out13`=={a[0],a[2],a[1],a[3]} (MSB/LSB swapped)
- On any mismatch:
  - `err_cnt` increments, saturating at 255.
  - If `fail_valid`=0, capture `fail_idx`←idx and set `fail_valid`.
- After CHECK: if idx==255 → DONE, else idx+1 → DRIVE.
- DONE (1 cycle): `done`=1, `pass`←(`err_cnt`==0) → IDLE.
- `start` outside IDLE is ignored. `start` held high in IDLE re-launches a sweep on the cycle after DONE.
- `in1`/`in2` are held stable from DRIVE through CHECK, and hold their last value in IDLE.

## Timing
- Reset: state IDLE. `in1`, `in2`, `busy`, `done`, `pass`, `err_cnt`, `fail_valid`, `fail_idx` are all 0.
- `busy`=1 in DRIVE, WAIT, CHECK and DONE.
- Per vector: `LATENCY`+2 cycles.
- Sweep: 256×(`LATENCY`+2) cycles from first DRIVE to DONE, plus 1 cycle for DONE.
- Observation inputs are sampled at the rising edge ending CHECK. The datapath must settle within `LATENCY` cycles after the edge that loads `in1`/`in2`; for LATENCY=0 it is combinational.
- Reset asserted mid-sweep aborts immediately to the reset values; no `done` pulse.
- Index wrap: 255 is the last vector; idx never wraps to 0 inside a sweep.

## Configuration
- `DIR_VEC_SEQ_STOP_ON_FAIL_EN` defined: a mismatch in CHECK goes directly to DONE.
  - `err_cnt`=1, `fail_idx` = failing vector, `pass`=0.
  - Remaining vectors are skipped.
- Undefined: full 256-vector sweep always; counting behaves as above.

## Structure
- Package `dir_vec_pkg`:
  - state encoding constants (IDLE=0, DRIVE=1, WAIT=2, CHECK=3, DONE=4, 3-bit)
  - `NUM_VECTORS`=256
  - `ERR_MAX`=255
- One sub-module, `dir_vec_check`: combinational expected-value compare taking a, `obs_*`, producing `mismatch`. It is reused when further outputs are added to the check list.

## Test plan
- Ideal datapath, LATENCY=1, pulse `start` → `done` after 768 busy cycles, then 1 DONE cycle. `pass`=1, `err_cnt`=0, `fail_valid`=0.
- `obs_out13` wired to `in1` (swap bug) → every vector whose bits 3 and 0 differ fails. `err_cnt`=128, `fail_idx`=0x01, `pass`=0.
- `obs_out3` stuck at 0, LATENCY=0 → `err_cnt`=240 (all a≠0), `fail_idx`=0x01, sweep length 512 cycles.
- `rst` pulsed at vector idx 40 mid-WAIT → all outputs 0 next cycle, no `done`. A subsequent `start` completes a clean sweep.
- `start` pulsed while `busy` → ignored; exactly one `done` pulse.
- With `DIR_VEC_SEQ_STOP_ON_FAIL_EN` and `obs_out1` bit 2 stuck at 1 → DONE after vector idx 0. `err_cnt`=1, `fail_idx`=0x00.
